// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between the decode stage, imm_extend_pipe and the execute stage.
// Optional o_noimm wire exists only when IMMEXT_NOIMM_FLAG_EN is defined.
interface imm_extend_pipe_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_instr;
    logic [1:0]      i_immsrc;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_immext;
`ifdef IMMEXT_NOIMM_FLAG_EN
    logic            o_noimm;
`endif

    // Block side: consumes instructions, produces immediates.
    modport slave (
        input  i_valid, i_instr, i_immsrc, i_ready,
        output o_ready, o_valid, o_immext
`ifdef IMMEXT_NOIMM_FLAG_EN
        , output o_noimm
`endif
    );

    // Environment side: drives instructions and downstream ready.
    modport master (
        output i_valid, i_instr, i_immsrc, i_ready,
        input  o_ready, o_valid, o_immext
`ifdef IMMEXT_NOIMM_FLAG_EN
        , input  o_noimm
`endif
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered RISC-V immediate extender with a 2-entry skid buffer (main + skid).
// Define IMMEXT_NOIMM_FLAG_EN to carry an o_noimm flag alongside each beat.
module imm_extend_pipe #(
    parameter int XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    imm_extend_pipe_if.slave   bus
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("imm_extend_pipe: only XLEN=32 is supported");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            ready_q;
    logic            valid_q;
    logic            load_main;
    logic            load_skid;
    logic            main_from_skid;
    logic            accept;
    logic            send;
    logic [XLEN-1:0] ext_imm;
    logic [XLEN-1:0] main_imm;
    logic [XLEN-1:0] skid_imm;
    logic            unused_instr_bits;

    // Opcode bits never contribute to the immediate.
    assign unused_instr_bits = ^bus.i_instr[6:0];

    assign accept = bus.i_valid & ready_q;
    assign send   = valid_q & bus.i_ready;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ext_imm = '0;
        case (bus.i_immsrc)
            2'b00:   ext_imm = {{(XLEN-12){bus.i_instr[31]}}, bus.i_instr[31:20]};
            2'b01:   ext_imm = {{(XLEN-12){bus.i_instr[31]}}, bus.i_instr[31:25],
                                bus.i_instr[11:7]};
            2'b10:   ext_imm = {{(XLEN-13){bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                                bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
            default: ext_imm = '0;
        endcase
    end

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (accept && send) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (send) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (send) begin
                    state_next     = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake flags are flops so o_ready never sees i_ready combinationally.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != FULL);
            valid_q <= (state_next != EMPTY);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_imm <= '0;
        end else if (load_main) begin
            main_imm <= ext_imm;
        end else if (main_from_skid) begin
            main_imm <= skid_imm;
        end
    end

    // NOTE: the skid entry is storage only; it is never read while the state says it is empty, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (load_skid) begin
            skid_imm <= ext_imm;
        end
    end

`ifdef IMMEXT_NOIMM_FLAG_EN
    logic ext_noimm;
    logic main_noimm;
    logic skid_noimm;

    assign ext_noimm = (bus.i_immsrc == 2'b11);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_noimm <= 1'b0;
        end else if (load_main) begin
            main_noimm <= ext_noimm;
        end else if (main_from_skid) begin
            main_noimm <= skid_noimm;
        end
    end

    always_ff @(posedge i_clk) begin
        if (load_skid) begin
            skid_noimm <= ext_noimm;
        end
    end

    assign bus.o_noimm = main_noimm;
`endif

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_immext = main_imm;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and scoreboarded checks for imm_extend_pipe; outputs sampled 1ns after each rising edge.
// Build with +define+IMMEXT_NOIMM_FLAG_EN to also check the o_noimm flag.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    imm_extend_pipe_if #(.XLEN(32)) bus ();

    imm_extend_pipe #(.XLEN(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic [31:0] instr);
        bus.i_valid  = v;
        bus.i_immsrc = src;
        bus.i_instr  = instr;
    endtask

    // Reference immediate built from the instruction field layout.
    function automatic logic [31:0] ref_ext(input logic [1:0] src, input logic [31:0] ins);
        logic [31:0] r;
        case (src)
            2'd0:    r = {{20{ins[31]}}, ins[31:20]};
            2'd1:    r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'd2:    r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic get_noimm();
`ifdef IMMEXT_NOIMM_FLAG_EN
        return bus.o_noimm;
`else
        return 1'b0;
`endif
    endfunction

    localparam logic [31:0] INS_LW  = 32'hFFC1_2083;
    localparam logic [31:0] INS_SW  = 32'h0051_2423;
    localparam logic [31:0] INS_BEQ = 32'hFE00_0CE3;

    logic [32:0] sb[$];
    logic [32:0] exp_beat;
    logic [32:0] held_beat;
    logic        held;
    logic        r0;
    int          beats;

    initial begin
        drive(1'b0, 2'd0, 32'h0);
        bus.i_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("rst_immext", bus.o_immext, 32'h0);
        check("rst_noimm", {31'd0, get_noimm()}, 32'd0);

        // Single I, S and B beats with a ready consumer.
        bus.i_ready = 1'b1;
        drive(1'b1, 2'd0, INS_LW);
        tick();
        check("i_valid", {31'd0, bus.o_valid}, 32'd1);
        check("i_imm", bus.o_immext, 32'hFFFF_FFFC);
        drive(1'b1, 2'd1, INS_SW);
        tick();
        check("s_imm", bus.o_immext, 32'h0000_0008);
        drive(1'b1, 2'd2, INS_BEQ);
        tick();
        check("b_imm", bus.o_immext, 32'hFFFF_FFF8);
        drive(1'b0, 2'd0, 32'h0);
        tick();
        check("drain_valid", {31'd0, bus.o_valid}, 32'd0);

        // Back-pressure: A, B fill the buffer, C waits, then all drain in order.
        bus.i_ready = 1'b0;
        drive(1'b1, 2'd0, INS_LW);
        tick();
        drive(1'b1, 2'd1, INS_SW);
        tick();
        check("full_ready", {31'd0, bus.o_ready}, 32'd0);
        check("full_head", bus.o_immext, 32'hFFFF_FFFC);
        drive(1'b1, 2'd2, INS_BEQ);
        tick();
        check("hold_valid", {31'd0, bus.o_valid}, 32'd1);
        check("hold_head", bus.o_immext, 32'hFFFF_FFFC);
        check("hold_ready", {31'd0, bus.o_ready}, 32'd0);
        bus.i_ready = 1'b1;
        tick();
        check("order_b", bus.o_immext, 32'h0000_0008);
        check("order_b_ready", {31'd0, bus.o_ready}, 32'd1);
        tick();
        check("order_c", bus.o_immext, 32'hFFFF_FFF8);
        check("order_c_valid", {31'd0, bus.o_valid}, 32'd1);
        drive(1'b0, 2'd0, 32'h0);
        tick();
        check("order_end", {31'd0, bus.o_valid}, 32'd0);

        // Reset while FULL, with i_valid still high on the reset edge.
        bus.i_ready = 1'b0;
        drive(1'b1, 2'd0, INS_LW);
        tick();
        drive(1'b1, 2'd1, INS_SW);
        tick();
        check("pre_rst_full", {31'd0, bus.o_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, 32'h0);
        check("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("midrst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("midrst_immext", bus.o_immext, 32'h0);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale", {31'd0, bus.o_valid}, 32'd0);
        end

        // immsrc=11 yields zero; the flag build also reports it.
        drive(1'b1, 2'd3, 32'hFFFF_FFFF);
        tick();
        check("none_imm", bus.o_immext, 32'h0);
`ifdef IMMEXT_NOIMM_FLAG_EN
        check("none_flag", {31'd0, bus.o_noimm}, 32'd1);
`endif
        drive(1'b1, 2'd0, INS_LW);
        tick();
        check("after_none_imm", bus.o_immext, 32'hFFFF_FFFC);
`ifdef IMMEXT_NOIMM_FLAG_EN
        check("after_none_flag", {31'd0, bus.o_noimm}, 32'd0);
`endif
        drive(1'b0, 2'd0, 32'h0);
        tick();

        // Random traffic against a scoreboard, checking order, hold and ready independence.
        beats = 0;
        held  = 1'b0;
        for (int cyc = 0; cyc < 12000 && beats < 2000; cyc++) begin
            if (held) begin
                check("hold_v", {31'd0, bus.o_valid}, 32'd1);
                check("hold_d", bus.o_immext, held_beat[31:0]);
                check("hold_f", {31'd0, get_noimm()}, {31'd0, held_beat[32]});
            end
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom());
            bus.i_ready = 1'($urandom_range(0, 1));
            r0 = bus.o_ready;
            bus.i_ready = ~bus.i_ready;
            #1;
            check("ready_indep", {31'd0, bus.o_ready}, {31'd0, r0});
            bus.i_ready = ~bus.i_ready;
            #1;
            held = 1'b0;
            if (bus.o_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_beat = sb[0];
                    check("sb_data", bus.o_immext, exp_beat[31:0]);
                    check("sb_flag", {31'd0, get_noimm()}, {31'd0, exp_beat[32]});
                    if (bus.i_ready) begin
                        void'(sb.pop_front());
                    end else begin
                        held      = 1'b1;
                        held_beat = {get_noimm(), bus.o_immext};
                    end
                end
            end
            if (bus.i_valid && bus.o_ready) begin
`ifdef IMMEXT_NOIMM_FLAG_EN
                sb.push_back({bus.i_immsrc == 2'd3, ref_ext(bus.i_immsrc, bus.i_instr)});
`else
                sb.push_back({1'b0, ref_ext(bus.i_immsrc, bus.i_instr)});
`endif
                beats++;
            end
            tick();
        end
        check("rand_beats", beats, 32'd2000);

        drive(1'b0, 2'd0, 32'h0);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.o_valid && sb.size() != 0) begin
                exp_beat = sb.pop_front();
                check("drain_data", bus.o_immext, exp_beat[31:0]);
            end
            tick();
        end
        check("sb_empty", sb.size(), 32'd0);
        check("final_valid", {31'd0, bus.o_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
